// File: rtl/mips_host_seq.sv
// mips_host_seq: host command sequencer for the MIPS processor/memory top.
// Loads instruction/data words, starts a run, reads data memory back.
module mips_host_seq #(
  parameter int WIDTH   = 32,
  parameter int TO_BITS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_adr,
  input  logic [WIDTH-1:0] cmd_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic             mem_write_instr,
  output logic             mem_write_data,
  output logic             mem_read_data,
  output logic             mem_start,
  output logic [WIDTH-1:0] mem_instr_adr,
  output logic [WIDTH-1:0] mem_instr_in,
  output logic [WIDTH-1:0] mem_data_adr,
  output logic [WIDTH-1:0] mem_data_in,
  input  logic             mem_done,
  input  logic [WIDTH-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    IDLE, WINSTR, WDATA, START, RUN, RDADR, RDCAP, RSP
  } state_e;

  localparam logic [TO_BITS-1:0] CNT_ONE = TO_BITS'(1);
  // Last RUN cycle index before the counter reaches all-ones.
  localparam logic [TO_BITS-1:0] TO_LAST = {{(TO_BITS-1){1'b1}}, 1'b0};

  state_e             state_q;
  logic [TO_BITS-1:0] cnt_q;
  logic [TO_BITS-1:0] cnt_d;
  logic               started_q;
  logic               rsp_valid_q;
  logic               rsp_err_q;
  logic [WIDTH-1:0]   rsp_data_q;
  logic               wi_q;
  logic               wd_q;
  logic               rd_q;
  logic               st_q;
  logic [WIDTH-1:0]   iadr_q;
  logic [WIDTH-1:0]   idat_q;
  logic [WIDTH-1:0]   dadr_q;
  logic [WIDTH-1:0]   ddat_q;

  assign cnt_d = cnt_q + CNT_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      started_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      wi_q        <= 1'b0;
      wd_q        <= 1'b0;
      rd_q        <= 1'b0;
      st_q        <= 1'b0;
      iadr_q      <= '0;
      idat_q      <= '0;
      dadr_q      <= '0;
      ddat_q      <= '0;
    end else begin
      wi_q        <= 1'b0;
      wd_q        <= 1'b0;
      rd_q        <= 1'b0;
      st_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: if (cmd_valid) begin
          // Default is a rejection; permitted ops override below.
          state_q     <= RSP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b1;
          rsp_data_q  <= '0;
          unique case (cmd_op)
            2'b00: if (mem_done || !started_q) begin
              state_q     <= WINSTR;
              rsp_valid_q <= 1'b0;
              rsp_err_q   <= 1'b0;
              wi_q        <= 1'b1;
              iadr_q      <= cmd_adr;
              idat_q      <= cmd_wdata;
            end
            2'b01: if (mem_done) begin
              state_q     <= WDATA;
              rsp_valid_q <= 1'b0;
              rsp_err_q   <= 1'b0;
              wd_q        <= 1'b1;
              dadr_q      <= cmd_adr;
              ddat_q      <= cmd_wdata;
            end
            2'b10: begin
              state_q     <= START;
              rsp_valid_q <= 1'b0;
              rsp_err_q   <= 1'b0;
              st_q        <= 1'b1;
              started_q   <= 1'b1;
              cnt_q       <= '0;
            end
            2'b11: if (mem_done) begin
              state_q     <= RDADR;
              rsp_valid_q <= 1'b0;
              rsp_err_q   <= 1'b0;
              rd_q        <= 1'b1;
              dadr_q      <= cmd_adr;
            end
          endcase
        end
        WINSTR, WDATA: begin
          state_q     <= RSP;
          rsp_valid_q <= 1'b1;
        end
        START: begin
          state_q <= RUN;
          cnt_q   <= '0;
        end
        RUN: begin
          cnt_q <= cnt_d;
          // Done seen in the first RUN cycle may be left over from the last run.
          if (mem_done && cnt_q != '0) begin
            state_q     <= RSP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
          end else if (cnt_q == TO_LAST) begin
            state_q     <= RSP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
          end
        end
        RDADR: state_q <= RDCAP;
        RDCAP: begin
          state_q     <= RSP;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= mem_data_out;
        end
        RSP: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready       = (state_q == IDLE);
  assign busy            = (state_q != IDLE);
  assign rsp_valid       = rsp_valid_q;
  assign rsp_err         = rsp_err_q;
  assign rsp_data        = rsp_data_q;
  assign mem_write_instr = wi_q;
  assign mem_write_data  = wd_q;
  assign mem_read_data   = rd_q;
  assign mem_start       = st_q;
  assign mem_instr_adr   = iadr_q;
  assign mem_instr_in    = idat_q;
  assign mem_data_adr    = dadr_q;
  assign mem_data_in     = ddat_q;

endmodule

// File: tb/tb_mips_host_seq.sv
// tb_mips_host_seq: directed and random command streams against a
// processor/memory model and a command-level reference of the sequencer.
module tb_mips_host_seq;

  localparam int T = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;
  logic        mem_write_instr;
  logic        mem_write_data;
  logic        mem_read_data;
  logic        mem_start;
  logic [31:0] mem_instr_adr;
  logic [31:0] mem_instr_in;
  logic [31:0] mem_data_adr;
  logic [31:0] mem_data_in;
  logic        mem_done;
  logic [31:0] mem_data_out;

  mips_host_seq #(.WIDTH(32), .TO_BITS(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_adr(cmd_adr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy),
    .mem_write_instr(mem_write_instr), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data), .mem_start(mem_start),
    .mem_instr_adr(mem_instr_adr), .mem_instr_in(mem_instr_in),
    .mem_data_adr(mem_data_adr), .mem_data_in(mem_data_in),
    .mem_done(mem_done), .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Processor model: halts run_len cycles after start unless never is set.
  logic proc_done = 1'b0;
  int   proc_cnt = 0;
  int   run_len = 10;
  bit   never = 1'b0;
  bit   force_done = 1'b0;

  always @(posedge clk) begin
    if (mem_start) begin
      proc_done <= 1'b0;
      proc_cnt  <= run_len;
    end else if (proc_cnt > 0) begin
      proc_cnt <= proc_cnt - 1;
      if (proc_cnt == 1 && !never) proc_done <= 1'b1;
    end
  end
  assign mem_done = proc_done | force_done;

  // Data memory model with one-cycle read latency.
  logic [31:0] dmem [64] = '{default: 32'h0};
  logic [31:0] rdq = 32'h0;
  always @(posedge clk) begin
    if (mem_write_data) dmem[mem_data_adr[7:2]] <= mem_data_in;
    if (mem_read_data) rdq <= dmem[mem_data_adr[7:2]];
  end
  assign mem_data_out = rdq;

  // Reference state at command level.
  logic [31:0] ref_dmem [64] = '{default: 32'h0};
  bit ref_started = 1'b0;

  int n_tests = 0;
  int n_fail = 0;

  logic [166:0] zv;
  assign zv = {rsp_valid, rsp_err, rsp_data, mem_write_instr,
               mem_write_data, mem_read_data, mem_start,
               mem_instr_adr, mem_instr_in, mem_data_adr,
               mem_data_in, busy};

  function automatic logic [31:0] pk(int a, int b, int c, int d);
    return {8'(a), 8'(b), 8'(c), 8'(d)};
  endfunction

  function automatic int run_rc(bit frc, bit nev, int len);
    if (frc) return 2;
    if (nev) return 1000;
    return len + 1;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] adr,
                       input logic [31:0] wd, output logic acc,
                       output logic d_acc, output int lat,
                       output logic err, output logic [31:0] data,
                       output logic [31:0] cnts,
                       output logic [31:0] s_adr,
                       output logic [31:0] s_dat);
    int nwi, nwd, nrd, nst;
    nwi = 0; nwd = 0; nrd = 0; nst = 0;
    lat = -1; err = 1'b0; data = 32'h0;
    s_adr = 32'h0; s_dat = 32'h0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_adr = adr; cmd_wdata = wd;
    acc = cmd_ready;
    d_acc = mem_done;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cmd_adr = $urandom; cmd_wdata = $urandom;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      @(negedge clk);
      if (mem_write_instr) begin
        nwi++; s_adr = mem_instr_adr; s_dat = mem_instr_in;
      end
      if (mem_write_data) begin
        nwd++; s_adr = mem_data_adr; s_dat = mem_data_in;
      end
      if (mem_read_data) begin
        nrd++; s_adr = mem_data_adr;
      end
      if (mem_start) nst++;
      if (rsp_valid) begin
        lat = c; err = rsp_err; data = rsp_data;
      end
    end
    cnts = pk(nwi, nwd, nrd, nst);
  endtask

  logic        acc, d_acc, err;
  int          lat;
  logic [31:0] data, cnts, s_adr, s_dat;

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00;
    cmd_adr = 32'h0; cmd_wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_ready got %b exp 1", cmd_ready);
    end
    n_tests++;
    if (zv !== '0) begin
      n_fail++; $display("FAIL rst_outs got %h exp 0", zv);
    end
    reset = 1'b0;
    ref_started = 1'b0;
  endtask

  task automatic test_load_instr();
    issue(2'b00, 32'h4, 32'h20080005, acc, d_acc, lat, err, data,
          cnts, s_adr, s_dat);
    n_tests++;
    if (lat !== 2 || err !== 1'b0) begin
      n_fail++; $display("FAIL wi_rsp lat %0d err %b exp 2 0", lat, err);
    end
    n_tests++;
    if (cnts !== pk(1, 0, 0, 0)) begin
      n_fail++; $display("FAIL wi_strobes got %h exp %h", cnts, pk(1, 0, 0, 0));
    end
    n_tests++;
    if (s_adr !== 32'h4 || s_dat !== 32'h20080005) begin
      n_fail++; $display("FAIL wi_vals got %h %h exp 4 20080005", s_adr, s_dat);
    end
  endtask

  task automatic test_run();
    never = 1'b0; run_len = 10;
    issue(2'b10, 32'h0, 32'h0, acc, d_acc, lat, err, data,
          cnts, s_adr, s_dat);
    ref_started = 1'b1;
    n_tests++;
    if (lat !== 2 + 11 || err !== 1'b0) begin
      n_fail++; $display("FAIL run_rsp lat %0d err %b exp 13 0", lat, err);
    end
    n_tests++;
    if (cnts !== pk(0, 0, 0, 1)) begin
      n_fail++; $display("FAIL run_strobes got %h exp %h", cnts, pk(0, 0, 0, 1));
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL run_idle busy %b ready %b exp 0 1", busy, cmd_ready);
    end
  endtask

  task automatic test_write_read();
    issue(2'b01, 32'h8, 32'hDEADBEEF, acc, d_acc, lat, err, data,
          cnts, s_adr, s_dat);
    ref_dmem[2] = 32'hDEADBEEF;
    n_tests++;
    if (lat !== 2 || err !== 1'b0 || cnts !== pk(0, 1, 0, 0)) begin
      n_fail++; $display("FAIL wd_rsp lat %0d err %b cnts %h exp 2 0 %h",
                         lat, err, cnts, pk(0, 1, 0, 0));
    end
    n_tests++;
    if (s_adr !== 32'h8 || s_dat !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL wd_vals got %h %h exp 8 deadbeef", s_adr, s_dat);
    end
    issue(2'b11, 32'h8, 32'h0, acc, d_acc, lat, err, data,
          cnts, s_adr, s_dat);
    n_tests++;
    if (lat !== 3 || err !== 1'b0 || cnts !== pk(0, 0, 1, 0)) begin
      n_fail++; $display("FAIL rd_rsp lat %0d err %b cnts %h exp 3 0 %h",
                         lat, err, cnts, pk(0, 0, 1, 0));
    end
    n_tests++;
    if (data !== 32'hDEADBEEF || s_adr !== 32'h8) begin
      n_fail++; $display("FAIL rd_data got %h adr %h exp deadbeef 8", data, s_adr);
    end
  endtask

  task automatic test_reject();
    never = 1'b1; run_len = 3;
    issue(2'b10, 32'h0, 32'h0, acc, d_acc, lat, err, data,
          cnts, s_adr, s_dat);
    n_tests++;
    if (lat !== 2 + T || err !== 1'b1) begin
      n_fail++; $display("FAIL timeout lat %0d err %b exp 17 1", lat, err);
    end
    issue(2'b01, 32'h8, 32'h1, acc, d_acc, lat, err, data,
          cnts, s_adr, s_dat);
    n_tests++;
    if (lat !== 1 || err !== 1'b1 || cnts !== 32'h0) begin
      n_fail++; $display("FAIL rej_wd lat %0d err %b cnts %h exp 1 1 0", lat, err, cnts);
    end
    issue(2'b11, 32'h8, 32'h0, acc, d_acc, lat, err, data,
          cnts, s_adr, s_dat);
    n_tests++;
    if (lat !== 1 || err !== 1'b1 || cnts !== 32'h0 || data !== 32'h0) begin
      n_fail++; $display("FAIL rej_rd lat %0d err %b cnts %h data %h exp 1 1 0 0",
                         lat, err, cnts, data);
    end
    issue(2'b00, 32'h10, 32'h2, acc, d_acc, lat, err, data,
          cnts, s_adr, s_dat);
    n_tests++;
    if (lat !== 1 || err !== 1'b1 || cnts !== 32'h0) begin
      n_fail++; $display("FAIL rej_wi lat %0d err %b cnts %h exp 1 1 0", lat, err, cnts);
    end
  endtask

  task automatic test_timeout_edge();
    never = 1'b0; run_len = 14;
    issue(2'b10, 32'h0, 32'h0, acc, d_acc, lat, err, data,
          cnts, s_adr, s_dat);
    n_tests++;
    if (lat !== 2 + T || err !== 1'b0) begin
      n_fail++; $display("FAIL to_coincide lat %0d err %b exp 17 0", lat, err);
    end
    run_len = 15;
    issue(2'b10, 32'h0, 32'h0, acc, d_acc, lat, err, data,
          cnts, s_adr, s_dat);
    n_tests++;
    if (lat !== 2 + T || err !== 1'b1) begin
      n_fail++; $display("FAIL to_late lat %0d err %b exp 17 1", lat, err);
    end
  endtask

  task automatic test_stale_done();
    force_done = 1'b1; run_len = 10;
    issue(2'b10, 32'h0, 32'h0, acc, d_acc, lat, err, data,
          cnts, s_adr, s_dat);
    force_done = 1'b0;
    n_tests++;
    if (lat !== 4 || err !== 1'b0) begin
      n_fail++; $display("FAIL stale_done lat %0d err %b exp 4 0", lat, err);
    end
  endtask

  task automatic test_reset_mid_run();
    int nrsp;
    never = 1'b1; run_len = 5;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_busy got %b exp 1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1 || zv !== '0) begin
      n_fail++; $display("FAIL mid_rst ready %b outs %h exp 1 0", cmd_ready, zv);
    end
    reset = 1'b0;
    ref_started = 1'b0;
    nrsp = 0;
    repeat (20) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    n_tests++;
    if (nrsp !== 0) begin
      n_fail++; $display("FAIL mid_norsp got %0d exp 0", nrsp);
    end
    issue(2'b00, 32'h100, 32'h1234, acc, d_acc, lat, err, data,
          cnts, s_adr, s_dat);
    n_tests++;
    if (lat !== 2 || err !== 1'b0 || cnts !== pk(1, 0, 0, 0)) begin
      n_fail++; $display("FAIL post_rst_wi lat %0d err %b cnts %h exp 2 0 %h",
                         lat, err, cnts, pk(1, 0, 0, 0));
    end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] adr, wd, e_data, e_cnts;
    int          e_lat, rc;
    logic        e_err, ok;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      wd = $urandom;
      adr = (op == 2'b00) ? $urandom : {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      never = ($urandom_range(0, 9) == 0);
      run_len = $urandom_range(1, 16);
      issue(op, adr, wd, acc, d_acc, lat, err, data, cnts, s_adr, s_dat);
      e_data = 32'h0;
      case (op)
        2'b00: begin
          ok = d_acc || !ref_started;
          e_lat = ok ? 2 : 1;
          e_cnts = pk(ok ? 1 : 0, 0, 0, 0);
        end
        2'b01: begin
          ok = d_acc;
          e_lat = ok ? 2 : 1;
          e_cnts = pk(0, ok ? 1 : 0, 0, 0);
          if (ok) ref_dmem[adr[7:2]] = wd;
        end
        2'b10: begin
          ok = 1'b1;
          ref_started = 1'b1;
          rc = run_rc(1'b0, never, run_len);
          e_lat = (rc <= T) ? 2 + rc : 2 + T;
          e_cnts = pk(0, 0, 0, 1);
        end
        default: begin
          ok = d_acc;
          e_lat = ok ? 3 : 1;
          e_cnts = pk(0, 0, ok ? 1 : 0, 0);
          if (ok) e_data = ref_dmem[adr[7:2]];
        end
      endcase
      e_err = (op == 2'b10) ? (rc > T) : !ok;
      n_tests++;
      if (acc !== 1'b1 || lat !== e_lat || err !== e_err) begin
        n_fail++; $display("FAIL rnd%0d op%0d acc %b lat %0d err %b exp 1 %0d %b",
                           i, op, acc, lat, err, e_lat, e_err);
      end
      n_tests++;
      if (cnts !== e_cnts || data !== e_data) begin
        n_fail++; $display("FAIL rnd%0d op%0d cnts %h data %h exp %h %h",
                           i, op, cnts, data, e_cnts, e_data);
      end
      if (ok && op != 2'b10) begin
        n_tests++;
        if (s_adr !== adr || (op != 2'b11 && s_dat !== wd)) begin
          n_fail++; $display("FAIL rnd%0d op%0d strobe adr %h dat %h exp %h %h",
                             i, op, s_adr, s_dat, adr, wd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_instr();
    test_run();
    test_write_read();
    test_reject();
    test_timeout_edge();
    test_stale_done();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
